// File: rtl/clk_div_scheduler_pkg.sv
// Shared constants, types and helpers for the multi-channel clock divider.
// Imported by the interface, the channel sub-module and the top.
package clk_div_pkg;

    localparam int CW_DEF   = 26;
    localparam int DIV_STOP = 0;

    typedef logic [CW_DEF-1:0] div_t;

    // Index width that stays legal for a single-channel build.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_scheduler_if.sv
// Config handshake plus divided outputs, shared by the control master
// and the divider block.
interface clk_div_scheduler_if
    import clk_div_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = CW_DEF
);

    localparam int CHW = ch_width(NCH);

    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic [NCH-1:0] div_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] busy;

    modport master (
        output cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, div_out, tick, busy
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, div_out, tick, busy
    );

endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter with a shadowed ratio that is
// only adopted at the end of a full output period (or at once when stopped).
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int CW       = CW_DEF,
    parameter int INIT_DIV = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic [CW-1:0] load_val,
    output logic          div_out,
    output logic          tick,
    output logic          busy
);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cur_div_r;
    logic [CW-1:0] shadow_r;
    logic          div_out_r;
    logic          tick_r;
    logic          busy_r;

    logic [CW-1:0] cnt_s;
    logic [CW-1:0] cur_div_s;
    logic [CW-1:0] shadow_s;
    logic          div_out_s;
    logic          tick_s;
    logic          busy_s;
    logic          stopped_s;
    logic          wrap_s;

    // Next-state: stop handling, wrap/toggle, period-boundary apply, shadow load.
    always_comb begin
        cnt_s     = cnt_r;
        cur_div_s = cur_div_r;
        shadow_s  = shadow_r;
        div_out_s = div_out_r;
        tick_s    = 1'b0;
        busy_s    = busy_r;
        stopped_s = (cur_div_r == CW'(DIV_STOP));
        wrap_s    = !stopped_s && (cnt_r == (cur_div_r - CW'(1)));

        if (stopped_s) begin
            cnt_s     = '0;
            div_out_s = 1'b0;
            if (busy_r) begin
                cur_div_s = shadow_r;
                busy_s    = 1'b0;
            end else begin
                cur_div_s = cur_div_r;
            end
        end else if (wrap_s) begin
            cnt_s     = '0;
            div_out_s = ~div_out_r;
            tick_s    = 1'b1;
            // busy_r is the pre-edge value, so a same-edge accept never applies here.
            if (div_out_r && busy_r) begin
                cur_div_s = shadow_r;
                busy_s    = 1'b0;
            end else begin
                cur_div_s = cur_div_r;
            end
        end else begin
            cnt_s = cnt_r + CW'(1);
        end

        if (load_en) begin
            shadow_s = load_val;
            busy_s   = 1'b1;
        end else begin
            shadow_s = shadow_s;
        end
    end

    // Channel state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= '0;
            cur_div_r <= CW'(INIT_DIV);
            shadow_r  <= '0;
            div_out_r <= 1'b0;
            tick_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            cnt_r     <= cnt_s;
            cur_div_r <= cur_div_s;
            shadow_r  <= shadow_s;
            div_out_r <= div_out_s;
            tick_r    <= tick_s;
            busy_r    <= busy_s;
        end
    end

    assign div_out = div_out_r;
    assign tick    = tick_r;
    assign busy    = busy_r;

endmodule

// File: rtl/clk_div_scheduler.sv
// Runtime-programmable multi-channel clock divider. A single outstanding
// ratio update is accepted over the config handshake and routed to one channel.
module clk_div_scheduler
    import clk_div_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int CW       = CW_DEF,
    parameter int INIT_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    clk_div_scheduler_if.slave   cfg
);

    localparam int CHW = ch_width(NCH);

    logic           cfg_ready_r;
    logic           cfg_ready_s;
    logic           accept_s;
    logic [NCH-1:0] load_en_s;
    logic [NCH-1:0] div_out_s;
    logic [NCH-1:0] tick_s;
    logic [NCH-1:0] busy_s;

    // Handshake and channel decode; out-of-range indices load nothing.
    always_comb begin
        accept_s  = cfg.cfg_valid & cfg_ready_r;
        load_en_s = '0;
        for (int i = 0; i < NCH; i++) begin
            if (accept_s && (cfg.cfg_ch == CHW'(i))) begin
                load_en_s[i] = 1'b1;
            end else begin
                load_en_s[i] = 1'b0;
            end
        end
        // Drop ready on the accepting edge; reopen once every channel is idle.
        if (accept_s) begin
            cfg_ready_s = 1'b0;
        end else begin
            cfg_ready_s = ~|busy_s;
        end
    end

    // Config-ready register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ready_r <= 1'b1;
        end else begin
            cfg_ready_r <= cfg_ready_s;
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        clk_div_channel #(
            .CW       (CW),
            .INIT_DIV (INIT_DIV)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .load_en  (load_en_s[gi]),
            .load_val (cfg.cfg_div),
            .div_out  (div_out_s[gi]),
            .tick     (tick_s[gi]),
            .busy     (busy_s[gi])
        );
    end

    assign cfg.cfg_ready = cfg_ready_r;
    assign cfg.div_out   = div_out_s;
    assign cfg.tick      = tick_s;
    assign cfg.busy      = busy_s;

endmodule
